// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and byte helpers
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        XOR  = 2'd2
    } state_e;

    localparam logic [3:0] NR        = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam int         BYTE_W    = 8;
    localparam int         WORD_W    = 32;
    localparam int         KEY_W     = 128;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 0 is the most significant byte of a word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [1:0] i);
        case (i)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Word 0 is the most significant word of a key.
    function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] k,
                                                   input logic [1:0] i);
        case (i)
            2'd0:    return k[127:96];
            2'd1:    return k[95:64];
            2'd2:    return k[63:32];
            default: return k[31:0];
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - iterative AES-128 round-key expansion, one S-box byte per cycle
module aes_key_sched
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             key_ld,
    input  logic [KEY_W-1:0] key_in,
    input  logic             nxt,
    output logic [KEY_W-1:0] rk,
    output logic [3:0]       rnd,
    output logic             vld,
    output logic             busy,
    output logic             done
);

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [WORD_W-1:0]   tmp_q, tmp_d;
    logic [KEY_W-1:0]    rk_q, rk_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [BYTE_W-1:0]   rcon_q, rcon_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   w0, w1, w2, w3, rot_w3, t_w;
    logic [WORD_W-1:0]   w0_n, w1_n, w2_n, w3_n;
    logic [BYTE_W-1:0]   sbox_in, sbox_out;

    assign w0      = key_word(rk_q, 2'd0);
    assign w1      = key_word(rk_q, 2'd1);
    assign w2      = key_word(rk_q, 2'd2);
    assign w3      = key_word(rk_q, 2'd3);
    assign rot_w3  = {w3[23:0], w3[31:24]};
    assign sbox_in = word_byte(rot_w3, idx_q);

    assign t_w  = tmp_q ^ {rcon_q, 24'h000000};
    assign w0_n = w0 ^ t_w;
    assign w1_n = w1 ^ w0_n;
    assign w2_n = w2 ^ w1_n;
    assign w3_n = w3 ^ w2_n;

    aes_sbox u_sbox (
        .a (sbox_in),
        .y (sbox_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmp_d   = tmp_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        vld_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;

        // A load overrides everything, including an expansion in flight.
        if (key_ld) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            tmp_d   = '0;
            rk_d    = key_in;
            rnd_d   = 4'd0;
            rcon_d  = RCON_INIT;
            vld_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (nxt && (rnd_q < NR)) begin
                        state_d = SUB;
                        idx_d   = 2'd0;
                        busy_d  = 1'b1;
                    end
                end
                SUB: begin
                    case (idx_q)
                        2'd0:    tmp_d[31:24] = sbox_out;
                        2'd1:    tmp_d[23:16] = sbox_out;
                        2'd2:    tmp_d[15:8]  = sbox_out;
                        default: tmp_d[7:0]   = sbox_out;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = XOR;
                    end
                end
                XOR: begin
                    rk_d    = {w0_n, w1_n, w2_n, w3_n};
                    rnd_d   = rnd_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                    vld_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = ((rnd_q + 4'd1) == NR);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            tmp_q   <= '0;
            rk_q    <= '0;
            rnd_q   <= 4'd0;
            rcon_q  <= RCON_INIT;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmp_q   <= tmp_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rk   = rk_q;
    assign rnd  = rnd_q;
    assign vld  = vld_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// tb/tb_aes_key_sched.sv - randomized self-checking bench with a GF(2^8) reference model
module tb_aes_key_sched;

    logic         clk;
    logic         res;
    logic         key_ld;
    logic [127:0] key_in;
    logic         nxt;
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic         vld;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;

    logic [127:0] exp_rk;
    int           exp_rnd;

    localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] FIPS_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_key_sched dut (
        .clk    (clk),
        .res    (res),
        .key_ld (key_ld),
        .key_in (key_in),
        .nxt    (nxt),
        .rk     (rk),
        .rnd    (rnd),
        .vld    (vld),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] ref_rcon(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < r; i++) v = gmul(v, 8'h02);
        return v;
    endfunction

    // Next round key from round r's key, straight from the FIPS-197 recurrence.
    function automatic logic [127:0] ref_next(input logic [127:0] k, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {ref_sbox(w[3][23:16]), ref_sbox(w[3][15:8]),
             ref_sbox(w[3][7:0]),   ref_sbox(w[3][31:24])} ^ {ref_rcon(r), 24'h0};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in = k;
        key_ld = 1'b1;
        step();
        key_ld = 1'b0;
        exp_rk  = k;
        exp_rnd = 0;
    endtask

    task automatic issue_nxt(output int lat);
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        lat = 0;
        while (!vld && lat < 20) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        res = 1'b1; key_ld = 1'b0; nxt = 1'b0; key_in = '0;
        step(); step();
        n_checks++; if (rk !== 128'h0) begin n_fail++; $display("FAIL reset_rk got=%h exp=0", rk); end
        n_checks++; if ({rnd, vld, busy, done} !== 7'h0) begin n_fail++; $display("FAIL reset_ctl got=%h exp=0", {rnd, vld, busy, done}); end
        res = 1'b0;
        step();
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_release_vld got=%b exp=0", vld); end
        exp_rk = '0; exp_rnd = 0;
    endtask

    task automatic test_zero_key();
        int lat;
        issue_nxt(lat);
        n_checks++; if (lat != 5 || vld !== 1'b1) begin n_fail++; $display("FAIL zero_latency got=%0d vld=%b exp=5", lat, vld); end
        n_checks++; if (rk !== ZERO_R1) begin n_fail++; $display("FAIL zero_rk got=%h exp=%h", rk, ZERO_R1); end
        n_checks++; if (rk !== ref_next(exp_rk, 0)) begin n_fail++; $display("FAIL zero_model got=%h exp=%h", rk, ref_next(exp_rk, 0)); end
        n_checks++; if (rnd !== 4'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_rnd got=%0d busy=%b exp=1", rnd, busy); end
    endtask

    task automatic test_fips_schedule();
        int lat;
        load_key(FIPS_K);
        n_checks++; if (vld !== 1'b1 || rk !== FIPS_K || rnd !== 4'd0) begin n_fail++; $display("FAIL load_vld got vld=%b rk=%h rnd=%0d exp key rnd0", vld, rk, rnd); end
        for (int r = 0; r < 10; r++) begin
            issue_nxt(lat);
            n_checks++; if (lat != 5 || vld !== 1'b1) begin n_fail++; $display("FAIL fips_latency r=%0d got=%0d exp=5", r, lat); end
            n_checks++; if (rk !== ref_next(exp_rk, exp_rnd)) begin n_fail++; $display("FAIL fips_model r=%0d got=%h exp=%h", r, rk, ref_next(exp_rk, exp_rnd)); end
            exp_rk = ref_next(exp_rk, exp_rnd);
            exp_rnd++;
            n_checks++; if (rnd !== exp_rnd[3:0] || done !== (exp_rnd == 10)) begin n_fail++; $display("FAIL fips_rnd got=%0d done=%b exp=%0d", rnd, done, exp_rnd); end
            if (r == 0) begin
                n_checks++; if (rk !== FIPS_R1) begin n_fail++; $display("FAIL fips_r1 got=%h exp=%h", rk, FIPS_R1); end
            end
        end
        n_checks++; if (rk !== FIPS_R10 || done !== 1'b1) begin n_fail++; $display("FAIL fips_r10 got=%h done=%b exp=%h", rk, done, FIPS_R10); end
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            if (vld) lat++;
            step();
        end
        n_checks++; if (lat != 0 || rk !== FIPS_R10 || rnd !== 4'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL nxt_at_10 vld_count=%0d rk=%h rnd=%0d exp no change", lat, rk, rnd); end
    endtask

    task automatic test_busy_drop();
        int nvld;
        logic [127:0] held;
        load_key(rand_key());
        nvld = 0;
        held = rk;
        nxt = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            step();
            if (busy && rk !== held) begin
                n_checks++; n_fail++; $display("FAIL busy_stable step=%0d got=%h exp=%h", s, rk, held);
            end
            if (vld) begin
                nvld++;
                n_checks++; if (s % 6 != 0) begin n_fail++; $display("FAIL busy_spacing step=%0d exp multiple of 6", s); end
                n_checks++; if (rk !== ref_next(exp_rk, exp_rnd)) begin n_fail++; $display("FAIL busy_model got=%h exp=%h", rk, ref_next(exp_rk, exp_rnd)); end
                exp_rk = ref_next(exp_rk, exp_rnd);
                exp_rnd++;
            end
            held = rk;
        end
        nxt = 1'b0;
        n_checks++; if (nvld != 5 || rnd !== 4'd5) begin n_fail++; $display("FAIL busy_count got=%0d rnd=%0d exp=5", nvld, rnd); end
    endtask

    task automatic test_abort();
        int lat;
        logic [127:0] k3;
        load_key(rand_key());
        for (int r = 0; r < 3; r++) begin
            issue_nxt(lat);
            exp_rk = ref_next(exp_rk, exp_rnd);
            exp_rnd++;
        end
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b1 || rk !== exp_rk || rnd !== 4'd3) begin n_fail++; $display("FAIL abort_pre busy=%b rk=%h exp=%h", busy, rk, exp_rk); end
        k3 = rand_key();
        load_key(k3);
        n_checks++; if (vld !== 1'b1 || rk !== k3 || rnd !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_load vld=%b rk=%h rnd=%0d exp %h", vld, rk, rnd, k3); end
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (vld) lat++;
        end
        n_checks++; if (lat != 0 || rk !== k3) begin n_fail++; $display("FAIL abort_quiet vld_count=%0d rk=%h exp 0", lat, rk); end
        issue_nxt(lat);
        n_checks++; if (lat != 5 || rk !== ref_next(k3, 0) || rnd !== 4'd1) begin n_fail++; $display("FAIL abort_restart got=%h exp=%h", rk, ref_next(k3, 0)); end
    endtask

    task automatic test_ld_and_nxt();
        int nvld;
        logic [127:0] k;
        k = rand_key();
        key_in = k;
        key_ld = 1'b1;
        nxt = 1'b1;
        step();
        key_ld = 1'b0;
        nxt = 1'b0;
        n_checks++; if (vld !== 1'b1 || busy !== 1'b0 || rnd !== 4'd0) begin n_fail++; $display("FAIL ldnxt_load vld=%b busy=%b rnd=%0d exp 1 0 0", vld, busy, rnd); end
        nvld = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (vld) nvld++;
        end
        n_checks++; if (nvld != 0 || rk !== k) begin n_fail++; $display("FAIL ldnxt_drop vld_count=%0d rk=%h exp %h", nvld, rk, k); end
    endtask

    task automatic test_reset_mid();
        int nvld;
        load_key(rand_key());
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        step(); step(); step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
        res = 1'b1;
        #1;
        n_checks++; if (rk !== 128'h0 || {rnd, vld, busy, done} !== 7'h0) begin n_fail++; $display("FAIL rstmid_async rk=%h ctl=%h exp 0", rk, {rnd, vld, busy, done}); end
        step();
        res = 1'b0;
        nvld = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (vld) nvld++;
        end
        n_checks++; if (nvld != 0 || rk !== 128'h0 || rnd !== 4'd0) begin n_fail++; $display("FAIL rstmid_after vld_count=%0d rk=%h exp 0", nvld, rk); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        res = 1'b1; key_ld = 1'b0; nxt = 1'b0; key_in = '0;
        test_reset();
        test_zero_key();
        test_fips_schedule();
        test_busy_drop();
        test_abort();
        test_ld_and_nxt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
